// File: rtl/hs_mem_sdpram_rd_pkg.sv
// Shared types and constants for the SDPRAM burst-read streamer.
// The output buffer depth of 3 covers the 2-cycle issue-to-visible delay plus one held beat.
package hs_mem_sdpram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int OBUF_DEPTH = 3;
    localparam int OBUF_PTR_W = 2;
    localparam int OBUF_CNT_W = 2;

    function automatic logic [OBUF_PTR_W-1:0] obuf_ptr_inc(input logic [OBUF_PTR_W-1:0] p);
        return (p == OBUF_PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + OBUF_PTR_W'(1);
    endfunction

endpackage

// File: rtl/hs_mem_sdpram_rd_obuf.sv
// Three-entry in-order output buffer carrying data plus an end-of-burst flag.
// Storage is not reset; only the pointers and occupancy are.
module hs_mem_sdpram_rd_obuf
    import hs_mem_sdpram_rd_pkg::*;
#(
    parameter type DATA_TYPE = logic [7:0]
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  DATA_TYPE              i_data,
    input  logic                  i_last,
    input  logic                  i_pop,
    output logic                  o_valid,
    output DATA_TYPE              o_data,
    output logic                  o_last,
    output logic [OBUF_CNT_W-1:0] o_count
);

    DATA_TYPE              r_mem  [OBUF_DEPTH];
    logic                  r_last [OBUF_DEPTH];
    logic [OBUF_PTR_W-1:0] r_wr_ptr;
    logic [OBUF_PTR_W-1:0] r_rd_ptr;
    logic [OBUF_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= obuf_ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= obuf_ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + OBUF_CNT_W'(1);
                2'b01:   r_count <= r_count - OBUF_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr]  <= i_data;
            r_last[r_wr_ptr] <= i_last;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_last  = r_last[r_rd_ptr] & o_valid;
    assign o_count = r_count;

    // The issue throttle in the parent guarantees a free slot for every returning read.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && (r_count == OBUF_CNT_W'(OBUF_DEPTH))));

endmodule

// File: rtl/hs_mem_sdpram_rd_stream.sv
// Turns (addr, len) burst commands into latency-1 SDPRAM reads and a valid/ready beat stream.
// Reads are throttled on buffer occupancy plus the read in flight, so m_ready never reaches ren.
module hs_mem_sdpram_rd_stream
    import hs_mem_sdpram_rd_pkg::*;
#(
    parameter type DATA_TYPE  = logic [7:0],
    parameter int  DATA_DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
    localparam int LEN_WIDTH  = $clog2(DATA_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    input  DATA_TYPE              rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output DATA_TYPE              m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam int                    OCC_W     = OBUF_CNT_W + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [LEN_WIDTH-1:0]  r_left;
    logic                  r_rd_pend;
    logic                  r_rd_last;
    logic [OBUF_CNT_W-1:0] w_count;
    logic [OCC_W-1:0]      w_occ;
    logic                  w_ren;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_final_issue;
    logic                  w_drain_done;

    assign w_occ         = OCC_W'(w_count) + OCC_W'(r_rd_pend);
    assign w_accept      = cmd_valid && (r_state == ST_IDLE) && (cmd_len != '0);
    assign w_pop         = m_valid && m_ready;
    assign w_final_issue = w_ren && (r_left == LEN_WIDTH'(1));
    // Leave DRAIN as soon as the buffer will be empty after this cycle's pop.
    assign w_drain_done  = !r_rd_pend &&
                           ((w_count == '0) || ((w_count == OBUF_CNT_W'(1)) && w_pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)      w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_final_issue) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_done)  w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        busy      = (r_state != ST_IDLE);
        w_ren     = (r_state == ST_ISSUE) && (w_occ < OCC_W'(OBUF_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr   <= '0;
            r_left    <= '0;
            r_rd_pend <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_raddr <= cmd_addr;
                r_left  <= cmd_len;
            end else if (w_ren) begin
                r_raddr <= (r_raddr == ADDR_LAST) ? '0 : r_raddr + ADDR_WIDTH'(1);
                r_left  <= r_left - LEN_WIDTH'(1);
            end
            r_rd_pend <= w_ren;
            r_rd_last <= w_final_issue;
        end
    end

    assign ren   = w_ren;
    assign raddr = r_raddr;

    hs_mem_sdpram_rd_obuf #(
        .DATA_TYPE (DATA_TYPE)
    ) u_obuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_pend),
        .i_data  (rdata),
        .i_last  (r_rd_last),
        .i_pop   (w_pop),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_last  (m_last),
        .o_count (w_count)
    );

    a_cmd_addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (cmd_valid && cmd_ready) |-> (LEN_WIDTH'(cmd_addr) < LEN_WIDTH'(DATA_DEPTH)));

endmodule

// File: tb/tb_hs_mem_sdpram_rd_stream.sv
// Directed bench for the burst-read streamer with a latency-1 RAM model and a beat scoreboard.
module tb_hs_mem_sdpram_rd_stream;

    localparam int DEPTH = 16;
    localparam int LOGN  = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_addr;
    logic [4:0] cmd_len;
    logic [3:0] raddr;
    logic       ren;
    logic [7:0] rdata;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;

    hs_mem_sdpram_rd_stream #(
        .DATA_TYPE  (logic [7:0]),
        .DATA_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .raddr     (raddr),
        .ren       (ren),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ram[i] = 8'hA0 + 8'(i);
    always @(posedge clk) if (ren) rdata <= ram[raddr];

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         beats  = 0;
    logic [8:0] exp_q [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       ren_log  [LOGN];
    logic [3:0] raddr_log[LOGN];
    logic       mv_log   [LOGN];
    logic       cr_log   [LOGN];
    logic       busy_log [LOGN];
    logic [7:0] data_log [LOGN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then return just after the next rising edge.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        if (cyc < LOGN) begin
            ren_log[cyc]   = ren;
            raddr_log[cyc] = raddr;
            mv_log[cyc]    = m_valid;
            cr_log[cyc]    = cmd_ready;
            busy_log[cyc]  = busy;
            data_log[cyc]  = m_data;
        end
        if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
            chk("hold_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", m_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_data, e[7:0]);
                chk("beat_last", m_last, e[8]);
                beats++;
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int addr, input int len);
        cmd_valid = 1'b1;
        cmd_addr  = 4'(addr);
        cmd_len   = 5'(len);
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), 8'hA0 + 8'((addr + i) % DEPTH)});
        cyc = 0;
        step();
        chk("cmd_accept", cr_log[0], 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input bit rnd);
        int n = 0;
        while ((busy || m_valid || exp_q.size() != 0) && n < max_cyc) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        m_ready = 1'b1;
        chk("idle_reached", busy, 0);
        chk("sb_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        m_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ren", ren, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mlast", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Basic burst addr=3 len=4
        send_cmd(3, 4);
        repeat (9) step();
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("basic_ren_c%0d", c), ren_log[c], (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk($sformatf("basic_raddr_c%0d", c), raddr_log[c], 3 + c - 1);
            chk($sformatf("basic_mvalid_c%0d", c), mv_log[c], (c >= 3 && c <= 6));
            chk($sformatf("basic_cmd_ready_c%0d", c), cr_log[c], (c == 0 || c >= 7));
        end
        wait_idle(20, 1'b0);

        // Wrap addr=14 len=4
        send_cmd(14, 4);
        repeat (6) step();
        chk("wrap_raddr1", raddr_log[1], 14);
        chk("wrap_raddr2", raddr_log[2], 15);
        chk("wrap_raddr3", raddr_log[3], 0);
        chk("wrap_raddr4", raddr_log[4], 1);
        wait_idle(20, 1'b0);

        // Backpressure addr=3 len=8, m_ready low in cycles 3-8
        b0 = beats;
        send_cmd(3, 8);
        step();
        step();
        m_ready = 1'b0;
        repeat (6) step();
        m_ready = 1'b1;
        for (int c = 0; c < 9; c++)
            chk($sformatf("bp_ren_c%0d", c), ren_log[c], (c >= 1 && c <= 3));
        for (int c = 3; c < 9; c++) begin
            chk($sformatf("bp_mvalid_c%0d", c), mv_log[c], 1);
            chk($sformatf("bp_mdata_c%0d", c), data_log[c], 8'hA3);
        end
        wait_idle(60, 1'b0);
        chk("bp_beats", beats - b0, 8);

        // Zero length
        send_cmd(5, 0);
        repeat (5) step();
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("zl_ren_c%0d", c), ren_log[c], 0);
            chk($sformatf("zl_mvalid_c%0d", c), mv_log[c], 0);
            chk($sformatf("zl_busy_c%0d", c), busy_log[c], 0);
        end

        // Reset abort in cycle 4 of a len=8 burst
        send_cmd(0, 8);
        repeat (3) step();
        chk("abort_pre_mvalid", mv_log[3], 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ren", ren, 0);
        chk("abort_mvalid", m_valid, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        prev_stall = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        b0 = beats;
        send_cmd(0, 2);
        wait_idle(30, 1'b0);
        chk("abort_new_beats", beats - b0, 2);

        // Full depth with random backpressure
        b0 = beats;
        send_cmd(0, 16);
        wait_idle(400, 1'b1);
        chk("full_beats", beats - b0, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
